uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (byte write strobe plus busy flag) among NREQ requesters, e.g. the J1 CPU UART peripheral and a hardware status/debug streamer.
- Round-robin arbitration per byte, single-cycle ack handshake toward requesters.
- Sequences each transfer: issue strobe, wait for busy to rise, wait for busy to fall.
- Sits between requesters and the uart instance; drives its write-strobe and data inputs.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side handshake plus UART strobe/busy bundle.
// master = requesters and uart environment, slave = the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   lock;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              uart_wr;
    logic [7:0]        uart_dat;
    logic              uart_busy;
    logic              timeout_err;

    modport master (
        output req, req_data, lock, uart_busy,
        input  ack, grant, uart_wr, uart_dat, timeout_err
    );

    modport slave (
        input  req, req_data, lock, uart_busy,
        output ack, grant, uart_wr, uart_dat, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter per byte.
// Define UART_ARB_LOCK_EN to enable per-requester burst lock.
module uart_tx_arbiter #(
    parameter int NREQ         = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input logic              clk,
    input logic              rstn,
    uart_tx_arbiter_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            wr_q, wr_d;
    logic            to_q, to_d;
    logic [7:0]      dat_q, dat_d;
    logic            found;
    logic            start;

`ifdef UART_ARB_LOCK_EN
    logic [PW-1:0] own_q, own_d;
    logic          hold_q, hold_d;
    logic          held;

    assign held = hold_q & bus.lock[own_q];
`else
    logic unused_lock;

    assign unused_lock = ^bus.lock;
`endif

    // Search from the pointer and wrap, so the last winner goes last.
    always_comb begin
        elig = bus.req;
`ifdef UART_ARB_LOCK_EN
        if (held) elig = bus.req & (NREQ'(1) << own_q);
`endif
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && elig[(int'(ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    assign start = found & ~bus.uart_busy;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.uart_busy)          state_d = WAIT_LO;
                else if (cnt_q == CNT_LAST) state_d = IDLE;
            end
            WAIT_LO: begin
                if (!bus.uart_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d   = '0;
        wr_d    = 1'b0;
        to_d    = 1'b0;
        grant_d = grant_q;
        dat_d   = dat_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
`ifdef UART_ARB_LOCK_EN
        own_d   = own_q;
        hold_d  = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
`ifdef UART_ARB_LOCK_EN
                if (!held) hold_d = 1'b0;
`endif
                if (start) begin
                    wr_d    = 1'b1;
                    dat_d   = bus.req_data[8*int'(win) +: 8];
                    ack_d   = NREQ'(1) << win;
                    grant_d = NREQ'(1) << win;
                    ptr_d   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
`ifdef UART_ARB_LOCK_EN
                    own_d   = win;
`endif
                end
            end
            WAIT_HI: begin
                if (bus.uart_busy) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Byte stays acked; the requester has already moved on.
                    to_d    = 1'b1;
                    grant_d = '0;
                    cnt_d   = '0;
`ifdef UART_ARB_LOCK_EN
                    hold_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!bus.uart_busy) begin
                    grant_d = '0;
`ifdef UART_ARB_LOCK_EN
                    hold_d  = bus.lock[own_q];
`endif
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            grant_q <= '0;
            wr_q    <= 1'b0;
            dat_q   <= '0;
            to_q    <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            own_q   <= '0;
            hold_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            dat_q   <= dat_d;
            to_q    <= to_d;
`ifdef UART_ARB_LOCK_EN
            own_q   <= own_d;
            hold_q  <= hold_d;
`endif
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant       = grant_q;
    assign bus.uart_wr     = wr_q;
    assign bus.uart_dat    = dat_q;
    assign bus.timeout_err = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner cases and a
// randomized run against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;
    localparam int TO   = 16;
    localparam int NRND = 25;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NREQ        (NREQ),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // uart busy model: rises dly edges after a strobe, stays len edges
    logic mbusy  = 1'b0;
    bit   bforce = 1'b0;
    bit   bnever = 1'b0;
    bit   rnd_mode = 1'b0;
    int   bdly = 2;
    int   blen = 5;
    int   exp_to = 0;
    int   wait_c = 0;
    int   run_c  = 0;
    int   m_dly, m_len;
    bit   m_nev;

    assign bus.uart_busy = mbusy | bforce;

    always @(posedge clk) begin
        if (bus.uart_wr) begin
            if (rnd_mode) begin
                m_dly = $urandom_range(1, 4);
                m_len = $urandom_range(1, 6);
                m_nev = ($urandom_range(0, 7) == 0);
            end else begin
                m_dly = bdly;
                m_len = blen;
                m_nev = bnever;
            end
            if (m_nev) exp_to++;
            else       wait_c = m_dly;
        end else if (wait_c > 0) begin
            wait_c--;
            if (wait_c == 0) begin
                mbusy <= 1'b1;
                run_c = m_len;
            end
        end else if (run_c > 0) begin
            run_c--;
            if (run_c == 0) mbusy <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.uart_wr && cyc < 300);
        if (!bus.uart_wr) cyc = -1;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.grant != '0 && cyc < 300);
        if (bus.grant != '0) cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.req  = '0;
        bus.lock = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] ack;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n, viol, lastb, n0, w, base, nstrobe, obs;
        logic [1:0] eack [4];
        logic [7:0] edat [4];
        logic [7:0] q [NREQ][$];
        logic [NREQ-1:0] req_prev, acked, exp1h;
        logic busy_prev;
        int mptr;
        bit done;

        bus.req = '0;
        bus.req_data = '0;
        bus.lock = '0;

        // ack/dat follow round-robin from pointer 0 after reset
        tbl[0] = '{2'b01, 8'h11, 8'h22, 2'b01, 8'h11};
        tbl[1] = '{2'b11, 8'h33, 8'h44, 2'b10, 8'h44};
        tbl[2] = '{2'b11, 8'h55, 8'h66, 2'b01, 8'h55};
        tbl[3] = '{2'b01, 8'h77, 8'h88, 2'b01, 8'h77};
        tbl[4] = '{2'b10, 8'h99, 8'hA5, 2'b10, 8'hA5};
        tbl[5] = '{2'b10, 8'h00, 8'hFF, 2'b10, 8'hFF};
        tbl[6] = '{2'b11, 8'h12, 8'h34, 2'b01, 8'h12};
        tbl[7] = '{2'b11, 8'h56, 8'h78, 2'b10, 8'h78};

        repeat (2) @(negedge clk);
        chk("rst_ack", bus.ack, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_wr", bus.uart_wr, 0);
        chk("rst_dat", bus.uart_dat, 0);
        chk("rst_to", bus.timeout_err, 0);
        rstn = 1'b1;

        blen = 5;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.req = tbl[k].req;
            bus.req_data = {tbl[k].d1, tbl[k].d0};
            wait_strobe(cyc);
            chk($sformatf("vec%0d_lat", k), cyc, 1);
            chk($sformatf("vec%0d_ack", k), bus.ack, tbl[k].ack);
            chk($sformatf("vec%0d_grant", k), bus.grant, tbl[k].ack);
            chk($sformatf("vec%0d_dat", k), bus.uart_dat, tbl[k].dat);
            bus.req = '0;
            wait_idle(cyc);
            chk($sformatf("vec%0d_idle", k), bus.grant, 0);
        end

        // single byte, long busy: grant held until busy falls
        blen = 100;
        @(negedge clk);
        bus.req = 2'b10;
        bus.req_data = {8'hA5, 8'h00};
        wait_strobe(cyc);
        chk("one_lat", cyc, 1);
        chk("one_ack", bus.ack, 2'b10);
        chk("one_dat", bus.uart_dat, 8'hA5);
        bus.req = '0;
        viol = 0;
        lastb = -1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("one_wr_pulse", {bus.uart_wr, bus.ack}, 0);
            if (bus.uart_busy) begin
                lastb = n;
                if (bus.grant !== 2'b10) viol++;
            end
        end while (bus.grant != '0 && n < 400);
        chk("one_hold_viol", viol, 0);
        chk("one_release_lag", n - lastb, 2);

        // busy gating
        blen = 5;
        @(negedge clk);
        bforce = 1'b1;
        bus.req = 2'b01;
        bus.req_data = {8'h00, 8'h3C};
        viol = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.uart_wr || bus.ack != '0) viol++;
        end
        chk("gate_hold", viol, 0);
        bforce = 1'b0;
        wait_strobe(cyc);
        chk("gate_lat", cyc, 1);
        chk("gate_ack", bus.ack, 2'b01);
        chk("gate_dat", bus.uart_dat, 8'h3C);
        bus.req = '0;
        wait_idle(cyc);

        // timeout: busy never rises
        @(negedge clk);
        bnever = 1'b1;
        bus.req = 2'b10;
        bus.req_data = {8'hC3, 8'h00};
        wait_strobe(cyc);
        chk("to_ack", bus.ack, 2'b10);
        bus.req = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.timeout_err && n < 40);
        chk("to_lat", n, TO);
        chk("to_grant", bus.grant, 0);
        bnever = 1'b0;
        bus.req = 2'b01;
        bus.req_data = {8'h00, 8'h5E};
        @(negedge clk);
        chk("to_pulse", bus.timeout_err, 0);
        chk("to_next_wr", bus.uart_wr, 1);
        chk("to_next_ack", bus.ack, 2'b01);
        chk("to_next_dat", bus.uart_dat, 8'h5E);
        bus.req = '0;
        wait_idle(cyc);

        // reset during WAIT_LO
        blen = 20;
        @(negedge clk);
        bus.req = 2'b01;
        bus.req_data = {8'h00, 8'h5A};
        wait_strobe(cyc);
        bus.req = '0;
        n = 0;
        while (!bus.uart_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_ack", bus.ack, 0);
        chk("mid_rst_grant", bus.grant, 0);
        chk("mid_rst_wr", bus.uart_wr, 0);
        chk("mid_rst_dat", bus.uart_dat, 0);
        chk("mid_rst_to", bus.timeout_err, 0);
        rstn = 1'b1;
        bus.req = 2'b11;
        bus.req_data = {8'h22, 8'h11};
        wait_strobe(cyc);
        chk("mid_first_ack", bus.ack, 2'b01);
        chk("mid_first_grant", bus.grant, 2'b01);
        chk("mid_first_dat", bus.uart_dat, 8'h11);
        bus.req = '0;
        wait_idle(cyc);

        // burst lock on requester 0 while requester 1 waits
`ifdef UART_ARB_LOCK_EN
        eack = '{2'b01, 2'b01, 2'b01, 2'b10};
        edat = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
`else
        eack = '{2'b01, 2'b10, 2'b01, 2'b10};
        edat = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
`endif
        do_reset();
        blen = 3;
        bus.req = 2'b11;
        bus.lock = 2'b01;
        bus.req_data = {8'hB0, 8'hA0};
        n0 = 0;
        n = 0;
        for (int s = 0; s < 4; s++) begin
            wait_strobe(cyc);
            chk($sformatf("lock%0d_ack", s), bus.ack, eack[s]);
            chk($sformatf("lock%0d_dat", s), bus.uart_dat, edat[s]);
            if (bus.ack[0]) begin
                n0++;
                if (n0 == 3) begin
                    bus.req[0] = 1'b0;
                    bus.lock[0] = 1'b0;
                end else begin
                    bus.req_data[7:0] = 8'hA0 + 8'(n0);
                end
            end
            if (bus.ack[1]) begin
                n++;
                bus.req_data[15:8] = 8'hB0 + 8'(n);
            end
        end
        bus.req = '0;
        bus.lock = '0;
        wait_idle(cyc);

        // randomized traffic against round-robin model
        do_reset();
        rnd_mode = 1'b1;
        base = exp_to;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < NRND; j++)
                q[i].push_back(8'($urandom));
        mptr = 0;
        req_prev = '0;
        busy_prev = 1'b0;
        nstrobe = 0;
        obs = 0;
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            if (bus.timeout_err) obs++;
            acked = '0;
            if (bus.uart_wr) begin
                w = rr_pick(req_prev, mptr);
                nstrobe++;
                exp1h = (w >= 0) ? (NREQ'(1) << w) : '0;
                chk("rnd_busy_gate", busy_prev, 0);
                chk("rnd_ack", bus.ack, exp1h);
                chk("rnd_grant", bus.grant, exp1h);
                if (w >= 0) begin
                    chk("rnd_dat", bus.uart_dat, q[w][0]);
                    void'(q[w].pop_front());
                    acked[w] = 1'b1;
                    mptr = (w + 1) % NREQ;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acked[i]) begin
                    if (q[i].size() > 0 && $urandom_range(0, 1) == 1)
                        bus.req_data[8*i +: 8] = q[i][0];
                    else
                        bus.req[i] = 1'b0;
                end else if (!bus.req[i] && q[i].size() > 0 &&
                             $urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.req_data[8*i +: 8] = q[i][0];
                end
            end
            req_prev = bus.req;
            busy_prev = bus.uart_busy;
            done = 1'b1;
            for (int i = 0; i < NREQ; i++)
                if (q[i].size() != 0) done = 1'b0;
            if (bus.req != '0 || bus.grant != '0) done = 1'b0;
        end
        rnd_mode = 1'b0;
        chk("rnd_done", done, 1);
        chk("rnd_strobes", nstrobe, NREQ * NRND);
        chk("rnd_timeouts", obs, exp_to - base);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
